// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo_param                                              |
// | Description : Parametrised single-clock FIFO with registered read port,    |
// |               fill level, almost flags and sticky overflow/underflow.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = (1 << ADDR_W) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_req,
  input  logic              clear_err,
  output logic [DATA_W-1:0] read_data,
  output logic              rdata_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH       = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH     = (ADDR_W+1)'(DEPTH);
  localparam logic [31:0]     C_AFULL_TH  = 32'(AFULL_TH);
  localparam logic [31:0]     C_AEMPTY_TH = 32'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              w_rd_en;
  logic              w_wr_en;
  logic [ADDR_W:0]   w_level;
  logic [31:0]       w_level32;

  // Extra wrap bit keeps full (level == DEPTH) distinct from empty (level == 0).
  assign w_level   = wr_ptr_q - rd_ptr_q;
  assign w_level32 = 32'(w_level);

  assign fifo_empty   = (w_level == '0);
  assign fifo_full    = (w_level == C_DEPTH);
  assign almost_full  = (w_level32 >= C_AFULL_TH);
  assign almost_empty = (w_level32 <= C_AEMPTY_TH);
  assign level        = w_level;

  // A write into a full FIFO is only safe when a read frees a slot this cycle.
  assign w_rd_en = read_req & ~fifo_empty;
  assign w_wr_en = write_enable & (~fifo_full | w_rd_en);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    read_data_d   = read_data_q;
    rdata_valid_d = w_rd_en;
    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_rd_en) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      read_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
    // New errors take priority over a simultaneous clear.
    overflow_d  = (overflow_q  & ~clear_err) | (write_enable & ~w_wr_en);
    underflow_d = (underflow_q & ~clear_err) | (read_req     & ~w_rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      read_data_q   <= '0;
      rdata_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      read_data_q   <= read_data_d;
      rdata_valid_q <= rdata_valid_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= write_data;
    end
  end

  assign read_data   = read_data_q;
  assign rdata_valid = rdata_valid_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sync_fifo_param                                           |
// | Description : Scoreboard bench for sync_fifo_param, three configurations.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- DUT A: default configuration (32 x 16) ----------------
  logic        a_rst_n, a_we, a_rr, a_ce;
  logic [31:0] a_wd, a_rd;
  logic        a_rv, a_em, a_fu, a_af, a_ae, a_ov, a_un;
  logic [4:0]  a_lv;

  sync_fifo_param u_a (
    .clk(clk), .rst_n(a_rst_n), .write_enable(a_we), .write_data(a_wd),
    .read_req(a_rr), .clear_err(a_ce), .read_data(a_rd), .rdata_valid(a_rv),
    .fifo_empty(a_em), .fifo_full(a_fu), .almost_full(a_af), .almost_empty(a_ae),
    .level(a_lv), .overflow(a_ov), .underflow(a_un)
  );

  // ---------------- DUT T: threshold configuration ------------------------
  logic       t_we, t_rr, t_ce;
  logic [7:0] t_wd, t_rd;
  logic       t_rv, t_em, t_fu, t_af, t_ae, t_ov, t_un;
  logic [3:0] t_lv;
  logic       rst_n;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1)) u_t (
    .clk(clk), .rst_n(rst_n), .write_enable(t_we), .write_data(t_wd),
    .read_req(t_rr), .clear_err(t_ce), .read_data(t_rd), .rdata_valid(t_rv),
    .fifo_empty(t_em), .fifo_full(t_fu), .almost_full(t_af), .almost_empty(t_ae),
    .level(t_lv), .overflow(t_ov), .underflow(t_un)
  );

  // ---------------- DUT B: small random configuration (8 x 4) -------------
  logic       b_we, b_rr, b_ce;
  logic [7:0] b_wd, b_rd;
  logic       b_rv, b_em, b_fu, b_af, b_ae, b_ov, b_un;
  logic [2:0] b_lv;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .write_enable(b_we), .write_data(b_wd),
    .read_req(b_rr), .clear_err(b_ce), .read_data(b_rd), .rdata_valid(b_rv),
    .fifo_empty(b_em), .fifo_full(b_fu), .almost_full(b_af), .almost_empty(b_ae),
    .level(b_lv), .overflow(b_ov), .underflow(b_un)
  );

  // ---------------- reference models --------------------------------------
  logic [31:0] am_q[$];
  logic [31:0] aexp_q[$];
  bit          am_ov, am_un;
  logic [31:0] a_last;

  logic [7:0]  bm_q[$];
  logic [7:0]  bexp_q[$];
  bit          bm_ov, bm_un;
  logic [7:0]  b_last;

  // Monitors: pop an expected word whenever the DUT presents one.
  always @(negedge clk) begin
    if (a_rst_n && a_rv) begin
      if (aexp_q.size() == 0) chk("a_spurious_rvalid", 1, 0);
      else                    chk("a_rdata", 64'(a_rd), 64'(aexp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_rv) begin
      if (bexp_q.size() == 0) chk("b_spurious_rvalid", 1, 0);
      else                    chk("b_rdata", 64'(b_rd), 64'(bexp_q.pop_front()));
    end
  end

  task automatic a_cycle(input bit we, input logic [31:0] wd, input bit rr, input bit ce);
    bit rd_ok, wr_ok;
    a_we = we; a_wd = wd; a_rr = rr; a_ce = ce;
    rd_ok = rr && (am_q.size() != 0);
    wr_ok = we && ((am_q.size() < 16) || rd_ok);
    if (rd_ok) begin
      a_last = am_q.pop_front();
      aexp_q.push_back(a_last);
    end
    if (wr_ok) am_q.push_back(wd);
    am_ov = (am_ov && !ce) || (we && !wr_ok);
    am_un = (am_un && !ce) || (rr && !rd_ok);
    @(posedge clk);
    @(negedge clk);
    a_we = 1'b0; a_rr = 1'b0; a_ce = 1'b0;
    chk("a_level",    64'(a_lv), 64'(am_q.size()));
    chk("a_empty",    64'(a_em), 64'(am_q.size() == 0));
    chk("a_full",     64'(a_fu), 64'(am_q.size() == 16));
    chk("a_afull",    64'(a_af), 64'(am_q.size() >= 14));
    chk("a_aempty",   64'(a_ae), 64'(am_q.size() <= 2));
    chk("a_overflow", 64'(a_ov), 64'(am_ov));
    chk("a_underflow",64'(a_un), 64'(am_un));
    chk("a_rvalid",   64'(a_rv), 64'(rd_ok));
    chk("a_rdata_hold", 64'(a_rd), 64'(a_last));
  endtask

  task automatic b_cycle(input bit we, input logic [7:0] wd, input bit rr, input bit ce);
    bit rd_ok, wr_ok;
    b_we = we; b_wd = wd; b_rr = rr; b_ce = ce;
    rd_ok = rr && (bm_q.size() != 0);
    wr_ok = we && ((bm_q.size() < 4) || rd_ok);
    if (rd_ok) begin
      b_last = bm_q.pop_front();
      bexp_q.push_back(b_last);
    end
    if (wr_ok) bm_q.push_back(wd);
    bm_ov = (bm_ov && !ce) || (we && !wr_ok);
    bm_un = (bm_un && !ce) || (rr && !rd_ok);
    @(posedge clk);
    @(negedge clk);
    b_we = 1'b0; b_rr = 1'b0; b_ce = 1'b0;
    chk("b_level",    64'(b_lv), 64'(bm_q.size()));
    chk("b_full",     64'(b_fu), 64'(bm_q.size() == 4));
    chk("b_empty",    64'(b_em), 64'(bm_q.size() == 0));
    chk("b_afull",    64'(b_af), 64'(bm_q.size() >= 2));
    chk("b_aempty",   64'(b_ae), 64'(bm_q.size() <= 2));
    chk("b_overflow", 64'(b_ov), 64'(bm_ov));
    chk("b_underflow",64'(b_un), 64'(bm_un));
    chk("b_rvalid",   64'(b_rv), 64'(rd_ok));
  endtask

  task automatic t_cycle(input bit we, input logic [7:0] wd, input bit rr);
    t_we = we; t_wd = wd; t_rr = rr;
    @(posedge clk);
    @(negedge clk);
    t_we = 1'b0; t_rr = 1'b0;
  endtask

  task automatic a_drain_check(input string nm);
    a_cycle(0, 0, 0, 0);
    chk(nm, 64'(aexp_q.size()), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst_n = 0; rst_n = 0;
    a_we = 0; a_rr = 0; a_ce = 0; a_wd = '0;
    t_we = 0; t_rr = 0; t_ce = 0; t_wd = '0;
    b_we = 0; b_rr = 0; b_ce = 0; b_wd = '0;
    am_ov = 0; am_un = 0; a_last = '0;
    bm_ov = 0; bm_un = 0; b_last = '0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_level",  64'(a_lv), 0);
    chk("rst_empty",  64'(a_em), 1);
    chk("rst_full",   64'(a_fu), 0);
    chk("rst_afull",  64'(a_af), 0);
    chk("rst_aempty", 64'(a_ae), 1);
    chk("rst_rvalid", 64'(a_rv), 0);
    chk("rst_rdata",  64'(a_rd), 0);
    chk("rst_ovf",    64'(a_ov), 0);
    chk("rst_unf",    64'(a_un), 0);
    a_rst_n = 1; rst_n = 1;
    @(negedge clk);

    // Fill, drain and wrap (four passes through the pointer space)
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 16; i++) a_cycle(1, 32'((rep << 8) | i), 0, 0);
      chk("fill_full", 64'(a_fu), 1);
      for (int i = 0; i < 16; i++) a_cycle(0, 0, 1, 0);
      chk("drain_empty", 64'(a_em), 1);
    end
    a_drain_check("wrap_pending");

    // Overflow: 17th write dropped, stored words intact
    for (int i = 0; i < 17; i++) a_cycle(1, 32'h100 + 32'(i), 0, 0);
    chk("ovf_set", 64'(a_ov), 1);
    for (int i = 0; i < 16; i++) a_cycle(0, 0, 1, 0);
    a_cycle(0, 0, 0, 1);
    chk("ovf_clear", 64'(a_ov), 0);
    a_drain_check("ovf_pending");

    // Simultaneous read+write at full, then at empty
    for (int i = 0; i < 16; i++) a_cycle(1, 32'h200 + 32'(i), 0, 0);
    a_cycle(1, 32'hA5A5A5A5, 1, 0);
    chk("full_rw_level", 64'(a_lv), 16);
    chk("full_rw_ovf",   64'(a_ov), 0);
    for (int i = 0; i < 16; i++) a_cycle(0, 0, 1, 0);
    chk("full_rw_last", 64'(a_rd), 64'(32'hA5A5A5A5));
    a_cycle(1, 32'h5A5A5A5A, 1, 0);
    chk("empty_rw_level", 64'(a_lv), 1);
    chk("empty_rw_unf",   64'(a_un), 1);
    a_cycle(0, 0, 1, 0);
    a_cycle(0, 0, 1, 1);
    chk("set_beats_clear", 64'(a_un), 1);
    a_cycle(0, 0, 0, 1);
    a_drain_check("sim_pending");

    // Asynchronous reset mid-stream at level 5 with a valid read word showing
    for (int i = 0; i < 6; i++) a_cycle(1, 32'h300 + 32'(i), 0, 0);
    a_cycle(0, 0, 1, 0);
    chk("pre_rst_level", 64'(a_lv), 5);
    #2;
    a_rst_n = 0;
    #1;
    chk("arst_level",  64'(a_lv), 0);
    chk("arst_empty",  64'(a_em), 1);
    chk("arst_rvalid", 64'(a_rv), 0);
    chk("arst_rdata",  64'(a_rd), 0);
    am_q.delete(); aexp_q.delete(); am_ov = 0; am_un = 0; a_last = '0;
    @(negedge clk);
    a_rst_n = 1;
    a_cycle(1, 32'hCAFE0001, 0, 0);
    a_cycle(0, 0, 1, 0);
    a_drain_check("post_rst_pending");

    // Thresholds: ADDR_W=3, AFULL_TH=6, AEMPTY_TH=1
    for (int i = 0; i <= 8; i++) begin
      chk("th_up_level",  64'(t_lv), 64'(i));
      chk("th_up_aempty", 64'(t_ae), 64'(i <= 1));
      chk("th_up_afull",  64'(t_af), 64'(i >= 6));
      if (i < 8) t_cycle(1, 8'(i + 8'h40), 0);
    end
    chk("th_full", 64'(t_fu), 1);
    for (int i = 8; i > 0; i--) begin
      t_cycle(0, 0, 1);
      chk("th_rdata",     64'(t_rd), 64'(8'h40 + 8'(8 - i)));
      chk("th_rvalid",    64'(t_rv), 1);
      chk("th_dn_level",  64'(t_lv), 64'(i - 1));
      chk("th_dn_aempty", 64'(t_ae), 64'((i - 1) <= 1));
      chk("th_dn_afull",  64'(t_af), 64'((i - 1) >= 6));
    end
    chk("th_ovf_unf", 64'({t_ov, t_un}), 0);

    // Randomised traffic against the queue model
    for (int n = 0; n < 10000; n++) begin
      b_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 19) == 0));
    end
    b_cycle(0, 0, 0, 0);
    chk("rand_pending", 64'(bexp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
